router_sync_n: RTL and testbench

//  Parametrised synchroniser between the router FSM/register stage and NUM_CH output FIFOs.
//  - Latches the destination address from the header.
//  - Steers write enables and selects the full flag for the addressed FIFO.
//  - Per channel, raises a soft reset when valid data goes unread for TIMEOUT cycles.
//  - Adds an invalid-address flag, a configurable soft-reset pulse width and sticky timeout status.

---
 rtl/router_pkg.sv | 34 +++
 rtl/router_sync_tmo.sv | 95 +++++++++
 rtl/router_sync_n.sv | 147 ++++++++++++++
 tb/tb_router_sync_n.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
//   Shared constants, types and helpers for the router output synchroniser.
//   - ROUTER_NUM_CH / ROUTER_TIMEOUT : default channel count and unread timeout.
//   - ROUTER_MAX_CH                  : widest channel vector the onehot helper
//                                      can produce.
//   - tmo_state_t                    : per-channel timeout FSM state.
//   - onehot(addr, n)                : one-hot vector with bit 'addr' set when
//                                      addr < n, all zeros otherwise.
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_TIMEOUT = 30;
  localparam int ROUTER_MAX_CH  = 32;

  // COUNT: watching for consecutive unread-valid cycles.
  // PULSE: driving the channel soft reset for the configured number of cycles.
  typedef enum logic {
    TMO_COUNT = 1'b0,
    TMO_PULSE = 1'b1
  } tmo_state_t;

  // Out-of-range addresses decode to all zeros so a bad address can never
  // steer a write anywhere.
  function automatic logic [ROUTER_MAX_CH-1:0] onehot(input int unsigned addr,
                                                      input int unsigned n);
    logic [ROUTER_MAX_CH-1:0] v;
    v = '0;
    if (addr < n) v = ROUTER_MAX_CH'(1) << addr;
    return v;
  endfunction

endpackage

// File: rtl/router_sync_tmo.sv
// -----------------------------------------------------------------------------
// router_sync_tmo
//   Timeout supervisor for one output channel. Counts consecutive clock edges
//   on which the channel holds valid data that nobody reads. After TIMEOUT such
//   edges it enters PULSE for exactly SR_HOLD cycles (the parent decodes PULSE
//   as the channel soft reset) and sets a sticky timeout flag.
//
// Parameters
//   TIMEOUT  consecutive qualifying edges before the pulse fires (>=1)
//   SR_HOLD  pulse width in cycles (>=1)
//
// Ports
//   clock        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   qualify      in   valid data present and not being read this cycle
//   timeout_clr  in   clear the sticky flag (a simultaneous new timeout wins)
//   state        out  current FSM state (also used as the soft-reset source)
//   timeout_sts  out  sticky timeout flag
// -----------------------------------------------------------------------------
module router_sync_tmo
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT,
  parameter int SR_HOLD = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       qualify,
  input  logic       timeout_clr,
  output tmo_state_t state,
  output logic       timeout_sts
);

  // Counter is sized to hold TIMEOUT, so it can never wrap before firing.
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(SR_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SR_HOLD - 1);

  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic          fire;

  // The TIMEOUT-th consecutive qualifying edge starts the pulse.
  assign fire = (state == TMO_COUNT) && qualify && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= TMO_COUNT;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        TMO_COUNT: begin
          if (!qualify) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= TMO_PULSE;
            cnt   <= '0;
            hold  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TMO_PULSE: begin
          // Pulse width is fixed; channel activity is ignored while it runs.
          // The edge that ends the pulse is not counted as a qualifying edge.
          if (hold == HOLD_LAST) begin
            state <= TMO_COUNT;
            hold  <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: begin
          state <= TMO_COUNT;
          cnt   <= '0;
          hold  <= '0;
        end
      endcase
    end
  end

  // Sticky flag: setting takes priority over clearing on the same edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timeout_sts <= 1'b0;
    end else if (fire) begin
      timeout_sts <= 1'b1;
    end else if (timeout_clr) begin
      timeout_sts <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// -----------------------------------------------------------------------------
// router_sync_n
//   Synchroniser between the router FSM/register stage and NUM_CH output FIFOs.
//   Latches the destination address from the packet header, steers the FSM
//   write request to the addressed FIFO, returns that FIFO's full flag, flags
//   addresses with no FIFO behind them, and soft-resets any FIFO whose valid
//   data sits unread for TIMEOUT cycles.
//
// Parameters
//   NUM_CH   number of output channels (>=1)
//   ADDR_W   address field width, 2**ADDR_W >= NUM_CH
//   TIMEOUT  consecutive unread-valid cycles before a soft reset (>=1)
//   SR_HOLD  soft reset pulse width in cycles (>=1)
//
// Ports
//   clock          in   rising-edge clock
//   resetn         in   asynchronous active-low reset
//   detect_add     in   header present, latch data_in as the address
//   data_in        in   destination address
//   write_enb_reg  in   FSM write request
//   read_enb       in   per-channel FIFO read enable
//   full           in   per-channel FIFO full
//   empty          in   per-channel FIFO empty
//   timeout_clr    in   clear all sticky timeout flags
//   vld_out        out  per-channel data valid (~empty), combinational
//   write_enb      out  one-hot FIFO write enable, combinational
//   fifo_full      out  full flag of the addressed FIFO, combinational
//   addr_err       out  latched address has no FIFO (registered)
//   soft_reset     out  per-channel FIFO soft reset (registered)
//   timeout_sts    out  sticky per-channel timeout flag (registered)
//
// vld_out is a level, not a handshake: a channel counts as "valid" on any
// cycle its FIFO is non-empty, and "read" on any cycle read_enb is high for it.
// A cycle with valid high and read low is an unread-valid cycle.
// -----------------------------------------------------------------------------
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = ROUTER_TIMEOUT,
  parameter int SR_HOLD = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic              timeout_clr,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              addr_err,
  output logic [NUM_CH-1:0] soft_reset,
  output logic [NUM_CH-1:0] timeout_sts
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (NUM_CH < 1 || NUM_CH > ROUTER_MAX_CH) begin : g_bad_num_ch
      $error("router_sync_n: NUM_CH must be in 1..%0d", ROUTER_MAX_CH);
    end
    if (ADDR_W < 1 || (1 << ADDR_W) < NUM_CH) begin : g_bad_addr_w
      $error("router_sync_n: ADDR_W too narrow to address NUM_CH channels");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("router_sync_n: TIMEOUT must be >= 1");
    end
    if (SR_HOLD < 1) begin : g_bad_sr_hold
      $error("router_sync_n: SR_HOLD must be >= 1");
    end
  endgenerate

  // NUM_CH widened by one bit so the range compare is exact even when
  // NUM_CH == 2**ADDR_W.
  localparam logic [ADDR_W:0] NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

  // ---------------------------------------------------------------------------
  // Address latch
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_q;
  logic              addr_valid;
  logic              addr_ok;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (detect_add) begin
      addr_q     <= data_in;
      addr_valid <= 1'b1;
      addr_err   <= ({1'b0, data_in} >= NUM_CH_EXT);
    end
  end

  // Steering always uses the registered address: a header and a write request
  // in the same cycle still go to the previously latched channel.
  assign addr_ok = addr_valid & ~addr_err;

  // ---------------------------------------------------------------------------
  // Steering
  // ---------------------------------------------------------------------------
  logic sel_full;

  assign vld_out   = ~empty;
  assign write_enb = (write_enb_reg & addr_ok) ? NUM_CH'(onehot(32'(addr_q), NUM_CH))
                                               : '0;

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_q == ADDR_W'(i)) sel_full = full[i];
    end
  end

  assign fifo_full = addr_ok & sel_full;

  // ---------------------------------------------------------------------------
  // Per-channel timeout supervisors
  // ---------------------------------------------------------------------------
  tmo_state_t tmo_state [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    router_sync_tmo #(
      .TIMEOUT (TIMEOUT),
      .SR_HOLD (SR_HOLD)
    ) u_tmo (
      .clock       (clock),
      .resetn      (resetn),
      .qualify     (vld_out[i] & ~read_enb[i]),
      .timeout_clr (timeout_clr),
      .state       (tmo_state[i]),
      .timeout_sts (timeout_sts[i])
    );

    // The state register itself is the soft reset, so the output is glitch-free
    // and drops immediately with resetn.
    assign soft_reset[i] = (tmo_state[i] == TMO_PULSE);
  end

endmodule

// File: tb/tb_router_sync_n.sv
// -----------------------------------------------------------------------------
// tb_router_sync_n
//   Two instances: the default configuration (3 channels, TIMEOUT 30, 1-cycle
//   pulse) and a wide/short one (5 channels, ADDR_W 3, TIMEOUT 4, 3-cycle
//   pulse). Each cycle the driver applies inputs on the falling edge, asks the
//   reference model for the outputs expected in that cycle and queues them; the
//   monitor samples the DUTs late in the same low phase and compares.
//   The model tracks run lengths of unread-valid cycles and remaining pulse
//   cycles per channel, straight from the behavioural rules.
// -----------------------------------------------------------------------------
module tb_router_sync_n;

  localparam int A_N = 3, A_AW = 2, A_T = 30, A_H = 1;
  localparam int B_N = 5, B_AW = 3, B_T = 4,  B_H = 3;
  localparam int EW  = 22;  // {vld[5], we[5], sr[5], sts[5], ff, ae}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock;
  logic resetn;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic            a_detect, a_wreg, a_clr;
  logic [A_AW-1:0] a_data;
  logic [A_N-1:0]  a_rd, a_full, a_empty;
  logic [A_N-1:0]  a_vld, a_we, a_sr, a_sts;
  logic            a_ff, a_ae;

  logic            b_detect, b_wreg, b_clr;
  logic [B_AW-1:0] b_data;
  logic [B_N-1:0]  b_rd, b_full, b_empty;
  logic [B_N-1:0]  b_vld, b_we, b_sr, b_sts;
  logic            b_ff, b_ae;

  router_sync_n #(.NUM_CH(A_N), .ADDR_W(A_AW), .TIMEOUT(A_T), .SR_HOLD(A_H)) dut_a (
    .clock(clock), .resetn(resetn), .detect_add(a_detect), .data_in(a_data),
    .write_enb_reg(a_wreg), .read_enb(a_rd), .full(a_full), .empty(a_empty),
    .timeout_clr(a_clr), .vld_out(a_vld), .write_enb(a_we), .fifo_full(a_ff),
    .addr_err(a_ae), .soft_reset(a_sr), .timeout_sts(a_sts)
  );

  router_sync_n #(.NUM_CH(B_N), .ADDR_W(B_AW), .TIMEOUT(B_T), .SR_HOLD(B_H)) dut_b (
    .clock(clock), .resetn(resetn), .detect_add(b_detect), .data_in(b_data),
    .write_enb_reg(b_wreg), .read_enb(b_rd), .full(b_full), .empty(b_empty),
    .timeout_clr(b_clr), .vld_out(b_vld), .write_enb(b_we), .fifo_full(b_ff),
    .addr_err(b_ae), .soft_reset(b_sr), .timeout_sts(b_sts)
  );

  // ---------------------------------------------------------------------------
  // Next-cycle stimulus (index 0 = dut_a, 1 = dut_b)
  // ---------------------------------------------------------------------------
  logic       nx_rst;
  logic       nx_det  [2];
  logic [2:0] nx_data [2];
  logic       nx_wreg [2];
  logic [4:0] nx_rd   [2];
  logic [4:0] nx_full [2];
  logic [4:0] nx_empty[2];
  logic       nx_clr  [2];

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int         cfg_n [2] = '{A_N, B_N};
  int         cfg_t [2] = '{A_T, B_T};
  int         cfg_h [2] = '{A_H, B_H};
  logic [2:0] m_addr[2];
  bit         m_av  [2];
  bit         m_ae  [2];
  int         m_run [2][5];
  int         m_pl  [2][5];
  bit         m_sts [2][5];

  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_all();
    nx_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      nx_det[k]   = 1'b0;
      nx_data[k]  = '0;
      nx_wreg[k]  = 1'b0;
      nx_rd[k]    = '0;
      nx_full[k]  = '0;
      nx_empty[k] = 5'b11111;
      nx_clr[k]   = 1'b0;
    end
  endtask

  task automatic apply();
    resetn   = nx_rst;
    a_detect = nx_det[0];
    a_data   = nx_data[0][A_AW-1:0];
    a_wreg   = nx_wreg[0];
    a_rd     = nx_rd[0][A_N-1:0];
    a_full   = nx_full[0][A_N-1:0];
    a_empty  = nx_empty[0][A_N-1:0];
    a_clr    = nx_clr[0];
    b_detect = nx_det[1];
    b_data   = nx_data[1][B_AW-1:0];
    b_wreg   = nx_wreg[1];
    b_rd     = nx_rd[1][B_N-1:0];
    b_full   = nx_full[1][B_N-1:0];
    b_empty  = nx_empty[1][B_N-1:0];
    b_clr    = nx_clr[1];
  endtask

  // Expected outputs for the current cycle, then the effect of the next edge.
  task automatic model_step(input int k);
    logic [4:0]    vld, we, sr, sts;
    logic          ff;
    logic [EW-1:0] e;
    int            n;
    bit            fire;
    n = cfg_n[k];
    if (!nx_rst) begin
      m_addr[k] = '0;
      m_av[k]   = 1'b0;
      m_ae[k]   = 1'b0;
      for (int i = 0; i < 5; i++) begin
        m_run[k][i] = 0;
        m_pl[k][i]  = 0;
        m_sts[k][i] = 1'b0;
      end
    end
    vld = '0; we = '0; sr = '0; sts = '0; ff = 1'b0;
    for (int i = 0; i < n; i++) begin
      vld[i] = ~nx_empty[k][i];
      sr[i]  = (m_pl[k][i] > 0);
      sts[i] = m_sts[k][i];
    end
    if (m_av[k] && !m_ae[k]) begin
      ff = nx_full[k][m_addr[k]];
      if (nx_wreg[k]) we[m_addr[k]] = 1'b1;
    end
    e = {vld, we, sr, sts, ff, m_ae[k]};
    if (k == 0) exp_q_a.push_back(e);
    else        exp_q_b.push_back(e);

    if (nx_rst) begin
      for (int i = 0; i < n; i++) begin
        fire = 1'b0;
        if (m_pl[k][i] > 0) begin
          m_pl[k][i]--;
        end else if (!nx_empty[k][i] && !nx_rd[k][i]) begin
          m_run[k][i]++;
          if (m_run[k][i] == cfg_t[k]) begin
            m_run[k][i] = 0;
            m_pl[k][i]  = cfg_h[k];
            fire        = 1'b1;
          end
        end else begin
          m_run[k][i] = 0;
        end
        if (fire)           m_sts[k][i] = 1'b1;
        else if (nx_clr[k]) m_sts[k][i] = 1'b0;
      end
      if (nx_det[k]) begin
        m_addr[k] = nx_data[k];
        m_av[k]   = 1'b1;
        m_ae[k]   = (int'(nx_data[k]) >= n);
      end
    end
  endtask

  task automatic step_n(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      apply();
      #1;
      model_step(0);
      model_step(1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor
  // ---------------------------------------------------------------------------
  task automatic check_field(input string name, input int k,
                             input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut=%0d t=%0t actual=%b expected=%b", name, k, $time, act, exp);
    end
  endtask

  task automatic compare(input int k, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    check_field("vld_out",     k, act[21:17], exp[21:17]);
    check_field("write_enb",   k, act[16:12], exp[16:12]);
    check_field("soft_reset",  k, act[11:7],  exp[11:7]);
    check_field("timeout_sts", k, act[6:2],   exp[6:2]);
    check_field("fifo_full",   k, {4'b0, act[1]}, {4'b0, exp[1]});
    check_field("addr_err",    k, {4'b0, act[0]}, {4'b0, exp[0]});
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #4;
      if (exp_q_a.size() > 0)
        compare(0, {2'b0, a_vld, 2'b0, a_we, 2'b0, a_sr, 2'b0, a_sts, a_ff, a_ae},
                exp_q_a.pop_front());
      if (exp_q_b.size() > 0)
        compare(1, {b_vld, b_we, b_sr, b_sts, b_ff, b_ae}, exp_q_b.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    idle_all();
    nx_rst = 1'b0;
    apply();
    step_n(2);
    nx_rst = 1'b1;
    step_n(1);

    // Latch address 1 and write, then drop resetn mid-cycle with the request up.
    nx_det[0] = 1'b1; nx_data[0] = 3'd1; step_n(1);
    nx_det[0] = 1'b0; nx_wreg[0] = 1'b1; step_n(1);
    nx_rst = 1'b0; step_n(1);
    nx_rst = 1'b1; nx_wreg[0] = 1'b0; step_n(1);

    // Steering to channel 2 and its full flag.
    nx_det[0] = 1'b1; nx_data[0] = 3'd2; step_n(1);
    nx_det[0] = 1'b0; nx_wreg[0] = 1'b1; nx_full[0] = 5'b00100; step_n(1);
    nx_full[0] = 5'b00011; step_n(1);

    // Invalid address, then recovery; header + write in one cycle uses old address.
    nx_det[0] = 1'b1; nx_data[0] = 3'd3; nx_full[0] = 5'b00111; step_n(1);
    nx_det[0] = 1'b0; step_n(1);
    nx_det[0] = 1'b1; nx_data[0] = 3'd0; step_n(1);
    nx_det[0] = 1'b0; step_n(1);
    nx_det[0] = 1'b1; nx_data[0] = 3'd2; step_n(1);
    nx_det[0] = 1'b0; step_n(1);
    nx_wreg[0] = 1'b0; nx_full[0] = '0;

    // Channel 0 timeout on the 30th unread edge.
    nx_empty[0] = 5'b11110; step_n(32);
    nx_empty[0] = 5'b11111; step_n(3);
    // Read on edge 29 restarts the count.
    nx_empty[0] = 5'b11110; step_n(28);
    nx_rd[0] = 5'b00001; step_n(1);
    nx_rd[0] = 5'b00000; step_n(29);
    nx_empty[0] = 5'b11111; step_n(3);
    // Channel drains on edge 15.
    nx_empty[0] = 5'b11110; step_n(14);
    nx_empty[0] = 5'b11111; step_n(3);

    // Clear alone, then clear on the same edge as a new timeout.
    nx_clr[0] = 1'b1; step_n(1);
    nx_clr[0] = 1'b0; step_n(1);
    nx_empty[0] = 5'b11110; step_n(29);
    nx_clr[0] = 1'b1; step_n(1);
    nx_clr[0] = 1'b0; nx_empty[0] = 5'b11111; step_n(3);
    nx_clr[0] = 1'b1; step_n(1);
    nx_clr[0] = 1'b0; step_n(2);

    // Wide instance: channels 4 and 1 time out together; ch4 drains mid-pulse.
    nx_empty[1] = 5'b01101; step_n(4);
    nx_empty[1] = 5'b11111; step_n(5);
    // Staggered start on the same two channels.
    nx_empty[1] = 5'b01111; step_n(2);
    nx_empty[1] = 5'b01101; step_n(8);
    nx_empty[1] = 5'b11111; step_n(2);
    // Reset in the middle of a pulse.
    nx_empty[1] = 5'b01111; step_n(5);
    nx_rst = 1'b0; step_n(1);
    nx_rst = 1'b1; step_n(3);
    nx_empty[1] = 5'b11111; step_n(2);

    // Randomised traffic on both instances.
    for (int c = 0; c < 1500; c++) begin
      nx_rst = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < 2; k++) begin
        nx_det[k]  = ($urandom_range(0, 7) == 0);
        nx_data[k] = 3'($urandom_range(0, (k == 0) ? 3 : 7));
        nx_wreg[k] = 1'($urandom_range(0, 1));
        nx_full[k] = 5'($urandom_range(0, 31));
        nx_clr[k]  = ($urandom_range(0, 31) == 0);
        for (int i = 0; i < 5; i++) begin
          nx_rd[k][i]    = ($urandom_range(0, (k == 0) ? 15 : 3) == 0);
          nx_empty[k][i] = ($urandom_range(0, (k == 0) ? 15 : 3) == 0);
        end
      end
      step_n(1);
    end

    idle_all();
    step_n(2);
    @(negedge clock);
    #6;
    n_checks++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain actual=%0d/%0d expected=0/0", exp_q_a.size(), exp_q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
